// File: rtl/remote_pkg.sv
// Shared definitions for the remote key sequencer: default key width, FSM states, idle key code.
package remote_pkg;

   localparam int         KEY_W    = 8;
   localparam logic [7:0] KEY_NONE = 8'h00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } seq_state_e;

endpackage

// File: rtl/key_fifo.sv
// Synchronous DEPTH x KEY_W FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module key_fifo #(
   parameter int KEY_W = remote_pkg::KEY_W,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [KEY_W-1:0]       wdata_i,
   output logic [KEY_W-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             wr_en, rd_en;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers are power-of-two wide, so the increment wraps modulo DEPTH by itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // NOTE: storage has no reset; an entry is only read after count shows it was written.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/remote_key_sequencer.sv
// Edge-detects NEC decodes, filters repeats inside a hold window, queues keys and hands them out over valid/ack.
// Optional drop counter output enabled by defining REMOTE_DROP_CNT_EN.
module remote_key_sequencer
   import remote_pkg::*;
#(
   parameter int KEY_W       = remote_pkg::KEY_W,
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 1000,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_W-1:0]       tecla,
   input  logic                   ready,
   output logic [KEY_W-1:0]       key_out,
   output logic                   key_valid,
   input  logic                   key_ack,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow,
`ifdef REMOTE_DROP_CNT_EN
   output logic [7:0]             drop_cnt,
`endif
   input  logic                   clr_ovf
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 2);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(1);

   logic              ready_q;
   logic [KEY_W-1:0]  last_key_q, last_key_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   seq_state_e        state_q, state_d;
   logic [KEY_W-1:0]  key_out_q, key_out_d;
   logic              key_valid_q, key_valid_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              overflow_q;

   logic              capture, dup, push, pop, drop;
   logic [KEY_W-1:0]  head;
   logic              fifo_full, fifo_empty;

   assign capture = ready && !ready_q;
   assign dup     = capture && (tecla == last_key_q) && (hold_cnt_q != '0);
   assign push    = capture && !dup;
   assign pop     = (state_q == PRESENT) && key_ack;
   assign drop    = push && fifo_full && !pop;

   key_fifo #(
      .KEY_W (KEY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (tecla),
      .rdata_o (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // NOTE: every always_comb output gets its default first, so no path can infer a latch.
   always_comb begin
      last_key_d = last_key_q;
      hold_cnt_d = hold_cnt_q;
      if (capture) begin
         hold_cnt_d = HOLD_LOAD;
         if (!dup) last_key_d = tecla;
      end else if (hold_cnt_q != '0) begin
         hold_cnt_d = hold_cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      key_out_d   = key_out_q;
      key_valid_d = key_valid_q;
      gap_cnt_d   = gap_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               key_out_d   = head;
               key_valid_d = 1'b1;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            if (key_ack) begin
               key_valid_d = 1'b0;
               gap_cnt_d   = GAP_LOAD;
               state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q - 1'b1;
            if (gap_cnt_q == GAP_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q     <= 1'b0;
         last_key_q  <= KEY_W'(KEY_NONE);
         hold_cnt_q  <= '0;
         state_q     <= IDLE;
         key_out_q   <= '0;
         key_valid_q <= 1'b0;
         gap_cnt_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         ready_q     <= ready;
         last_key_q  <= last_key_d;
         hold_cnt_q  <= hold_cnt_d;
         state_q     <= state_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
         gap_cnt_q   <= gap_cnt_d;
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)         overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

   assign key_out   = key_out_q;
   assign key_valid = key_valid_q;
   assign overflow  = overflow_q;

`ifdef REMOTE_DROP_CNT_EN
   logic [7:0] drop_cnt_q;
   logic       drop_any;

   assign drop_any = dup || drop;

   always_ff @(posedge clk) begin
      if (rst)                                   drop_cnt_q <= '0;
      else if (clr_ovf)                          drop_cnt_q <= {7'd0, drop_any};
      else if (drop_any && drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'd1;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule
